branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit counters; combinational lookup, single-cycle update, no backpressure.
// Define BP_GSHARE_EN to index the counter array by PC XOR global history instead of PC alone.
module branch_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int ENTRIES     = 64,
    parameter int GHR_WIDTH   = 6,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  pcF,
    output logic                   predTakenF,
    output logic [DATA_WIDTH-1:0]  predTargetF,
    input  logic                   validE,
    input  logic                   isJumpE,
    input  logic                   jalrE,
    input  logic [DATA_WIDTH-1:0]  pcE,
    input  logic [DATA_WIDTH-1:0]  targetE,
    input  logic                   takenE,
    input  logic                   predTakenE,
    input  logic [DATA_WIDTH-1:0]  predTargetE,
    output logic                   mispredictE,
    output logic [DATA_WIDTH-1:0]  redirectPcE,
    output logic [COUNT_WIDTH-1:0] brCount,
    output logic [COUNT_WIDTH-1:0] mispCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    logic                  vld_q [ENTRIES];
    logic                  jmp_q [ENTRIES];
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];
    logic [1:0]            ctr_q [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e, cidx_f, cidx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e, upd;
    logic [1:0]       ctr_e, ctr_next;

    assign idx_f = pcF[IDX_W+1:2];
    assign tag_f = pcF[DATA_WIDTH-1:IDX_W+2];
    assign idx_e = pcE[IDX_W+1:2];
    assign tag_e = pcE[DATA_WIDTH-1:IDX_W+2];

    // jalr targets come from a register, so they are never cached
    assign upd = validE && !jalrE;

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q;
    logic [IDX_W-1:0]     ghr_ext;
    logic                 unused_bits;

    assign ghr_ext     = IDX_W'(ghr_q);
    assign cidx_f      = idx_f ^ ghr_ext;
    assign cidx_e      = idx_e ^ ghr_ext;
    assign unused_bits = ^{pcF[1:0], pcE[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd && !isJumpE) begin
            ghr_q <= GHR_WIDTH'({ghr_q, takenE});
        end
    end
`else
    logic unused_bits;

    assign cidx_f      = idx_f;
    assign cidx_e      = idx_e;
    assign unused_bits = ^{pcF[1:0], pcE[1:0], (GHR_WIDTH != 0)};
`endif

    assign hit_f       = vld_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign predTakenF  = hit_f && (jmp_q[idx_f] || ctr_q[cidx_f][1]);
    assign predTargetF = predTakenF ? tgt_q[idx_f] : '0;

    assign hit_e = vld_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign ctr_e = ctr_q[cidx_e];

    always_comb begin
        ctr_next = ctr_e;
        if (takenE) begin
            if (ctr_e != 2'b11) ctr_next = ctr_e + 2'd1;
        end else begin
            if (ctr_e != 2'b00) ctr_next = ctr_e - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld_q[i] <= 1'b0;
                jmp_q[i] <= 1'b0;
                ctr_q[i] <= 2'b01;
            end
        end else if (upd) begin
            if (hit_e) begin
                if (!isJumpE) ctr_q[cidx_e] <= ctr_next;
            end else if (takenE) begin
                vld_q[idx_e]  <= 1'b1;
                jmp_q[idx_e]  <= isJumpE;
                ctr_q[cidx_e] <= 2'b10;
            end
        end
    end

    // Tag/target need no reset: they are only visible through a set valid bit
    always_ff @(posedge clk) begin
        if (upd && takenE) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= targetE;
        end
    end

    assign mispredictE = validE ? ((predTakenE != takenE) || (takenE && (predTargetE != targetE)))
                                : predTakenE;
    assign redirectPcE = (validE && takenE) ? targetE : pcE + DATA_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brCount   <= '0;
            mispCount <= '0;
        end else begin
            if (validE && (brCount != '1))        brCount   <= brCount + COUNT_WIDTH'(1);
            if (mispredictE && (mispCount != '1)) mispCount <= mispCount + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=64, COUNT_WIDTH=4 so brCount saturation is reachable).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        validE, isJumpE, jalrE, takenE, predTakenE;
    logic [31:0] pcE, targetE, predTargetE;
    logic        mispredictE;
    logic [31:0] redirectPcE;
    logic [3:0]  brCount, mispCount;

    int total = 0;
    int bad   = 0;

    branch_predictor #(
        .DATA_WIDTH (32),
        .ENTRIES    (64),
        .GHR_WIDTH  (6),
        .COUNT_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pcF        (pcF),
        .predTakenF (predTakenF),
        .predTargetF(predTargetF),
        .validE     (validE),
        .isJumpE    (isJumpE),
        .jalrE      (jalrE),
        .pcE        (pcE),
        .targetE    (targetE),
        .takenE     (takenE),
        .predTakenE (predTakenE),
        .predTargetE(predTargetE),
        .mispredictE(mispredictE),
        .redirectPcE(redirectPcE),
        .brCount    (brCount),
        .mispCount  (mispCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        validE = 0; isJumpE = 0; jalrE = 0; takenE = 0;
        predTakenE = 0; predTargetE = 0; targetE = 0;
    endtask

    // Drive one EX resolution at the falling edge, settle, leave it for the caller to check
    task automatic resolve(input logic jmp, input logic jr, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic tk,
                           input logic pt, input logic [31:0] ptg);
        @(negedge clk);
        validE = 1; isJumpE = jmp; jalrE = jr; pcE = pc; targetE = tgt;
        takenE = tk; predTakenE = pt; predTargetE = ptg;
        #1;
    endtask

    task automatic edge_then_idle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_tk,
                          input logic [31:0] exp_tgt, input string tag);
        pcF = pc;
        #1;
        check({tag, ".taken"}, {31'b0, predTakenF}, {31'b0, exp_tk});
        check({tag, ".target"}, predTargetF, exp_tgt);
    endtask

    initial begin
        idle();
        pcE = 0;
        pcF = 32'h100;
        rst = 1;
        #12;
        check("rst.predTakenF", {31'b0, predTakenF}, 32'd0);
        check("rst.predTargetF", predTargetF, 32'h0);
        check("rst.brCount", {28'b0, brCount}, 32'd0);
        check("rst.mispCount", {28'b0, mispCount}, 32'd0);
        check("rst.redirect", redirectPcE, 32'h4);
        @(negedge clk);
        rst = 0;

        // First taken branch allocates; lookup in the same cycle still misses
        resolve(0, 0, 32'h100, 32'h80, 1, 0, 32'h0);
        check("alloc.misp", {31'b0, mispredictE}, 32'd1);
        check("alloc.redirect", redirectPcE, 32'h80);
        check("alloc.sameCycle", {31'b0, predTakenF}, 32'd0);
        edge_then_idle();
        lookup(32'h100, 1, 32'h80, "alloc.hit");
        check("alloc.brCount", {28'b0, brCount}, 32'd1);

        // Not-taken twice: counter 2 -> 1 -> 0
        resolve(0, 0, 32'h100, 32'h80, 0, 1, 32'h80);
        check("nt1.misp", {31'b0, mispredictE}, 32'd1);
        check("nt1.redirect", redirectPcE, 32'h104);
        edge_then_idle();
        lookup(32'h100, 0, 32'h0, "nt1");
        resolve(0, 0, 32'h100, 32'h80, 0, 1, 32'h80);
        check("nt2.misp", {31'b0, mispredictE}, 32'd1);
        check("nt2.redirect", redirectPcE, 32'h104);
        edge_then_idle();
        lookup(32'h100, 0, 32'h0, "nt2");
        check("nt2.mispCount", {28'b0, mispCount}, 32'd3);

        // jal at 0x200 aliases index 0 and evicts 0x100
        resolve(1, 0, 32'h200, 32'h400, 1, 0, 32'h0);
        check("jal.misp", {31'b0, mispredictE}, 32'd1);
        check("jal.redirect", redirectPcE, 32'h400);
        edge_then_idle();
        lookup(32'h200, 1, 32'h400, "jal.hit");
        lookup(32'h100, 0, 32'h0, "jal.evict");
        for (int i = 0; i < 5; i++) begin
            resolve(1, 0, 32'h200, 32'h400, 1, 1, 32'h400);
            check("jalrep.misp", {31'b0, mispredictE}, 32'd0);
            edge_then_idle();
            lookup(32'h200, 1, 32'h400, "jalrep");
        end
        check("jalrep.brCount", {28'b0, brCount}, 32'd9);
        check("jalrep.mispCount", {28'b0, mispCount}, 32'd4);

        // 0x100 re-allocates over 0x200; concurrent lookup of 0x200 sees old contents
        pcF = 32'h200;
        resolve(0, 0, 32'h100, 32'h80, 1, 0, 32'h0);
        check("alias.oldTaken", {31'b0, predTakenF}, 32'd1);
        check("alias.oldTarget", predTargetF, 32'h400);
        edge_then_idle();
        lookup(32'h200, 0, 32'h0, "alias.miss");
        lookup(32'h100, 1, 32'h80, "alias.hit");

        // jalr: counted, mispredicted, not allocated
        resolve(0, 1, 32'h300, 32'h500, 1, 0, 32'h0);
        check("jalr.misp", {31'b0, mispredictE}, 32'd1);
        check("jalr.redirect", redirectPcE, 32'h500);
        edge_then_idle();
        lookup(32'h300, 0, 32'h0, "jalr.noalloc");
        lookup(32'h100, 1, 32'h80, "jalr.keep");
        check("jalr.brCount", {28'b0, brCount}, 32'd11);
        check("jalr.mispCount", {28'b0, mispCount}, 32'd6);

        // Stale prediction on a non-branch
        @(negedge clk);
        pcE = 32'h300; predTakenE = 1;
        #1;
        check("stale.misp", {31'b0, mispredictE}, 32'd1);
        check("stale.redirect", redirectPcE, 32'h304);
        edge_then_idle();
        check("stale.brCount", {28'b0, brCount}, 32'd11);
        check("stale.mispCount", {28'b0, mispCount}, 32'd7);

        // Right direction, wrong target: mispredict, target rewritten, counter 2 -> 3
        resolve(0, 0, 32'h100, 32'h90, 1, 1, 32'h80);
        check("tgt.misp", {31'b0, mispredictE}, 32'd1);
        edge_then_idle();
        lookup(32'h100, 1, 32'h90, "tgt.rewrite");
        resolve(0, 0, 32'h100, 32'h90, 1, 1, 32'h90);
        check("good.misp", {31'b0, mispredictE}, 32'd0);
        edge_then_idle();

        // Five more correct resolutions push brCount from 13 past 15
        for (int i = 0; i < 5; i++) begin
            resolve(0, 0, 32'h100, 32'h90, 1, 1, 32'h90);
            edge_then_idle();
        end
        check("sat.brCount", {28'b0, brCount}, 32'd15);
        check("sat.mispCount", {28'b0, mispCount}, 32'd8);

        // Counter saturated at 3, so one not-taken still predicts taken
        resolve(0, 0, 32'h100, 32'h90, 0, 1, 32'h90);
        edge_then_idle();
        lookup(32'h100, 1, 32'h90, "ctrsat");
        check("ctrsat.mispCount", {28'b0, mispCount}, 32'd9);

        // Reset in the middle of an update discards it; first post-reset edge is accepted
        pcF = 32'h100;
        resolve(0, 0, 32'h200, 32'h600, 1, 0, 32'h0);
        rst = 1;
        #1;
        check("midrst.taken", {31'b0, predTakenF}, 32'd0);
        check("midrst.brCount", {28'b0, brCount}, 32'd0);
        check("midrst.mispCount", {28'b0, mispCount}, 32'd0);
        @(posedge clk);
        #1;
        lookup(32'h200, 0, 32'h0, "midrst.noupd");
        @(negedge clk);
        rst = 0;
        edge_then_idle();
        lookup(32'h200, 1, 32'h600, "postrst.alloc");
        lookup(32'h100, 0, 32'h0, "postrst.cleared");
        check("postrst.brCount", {28'b0, brCount}, 32'd1);
        check("postrst.mispCount", {28'b0, mispCount}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
